// File: rtl/encoded_grant_decoder.sv
// Receive side of the priority-encoder link: expands a valid index into a
// registered one-hot grant held until ack or hold timeout, with one pending slot.
module encoded_grant_decoder #(
    parameter int CODE_W   = 2,
    parameter int HOLD_MAX = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CODE_W-1:0]      code_in,
    input  logic                   code_valid,
    output logic                   code_ready,
    output logic [2**CODE_W-1:0]   grant,
    output logic                   grant_valid,
    input  logic                   ack,
    output logic                   timeout,
    output logic                   busy
);

    localparam int N     = 2 ** CODE_W;
    localparam int CNT_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD_MAX);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RECOVER
    } state_t;

    state_t              state_q;
    logic [N-1:0]        grant_q;
    logic                gv_q;
    logic                timeout_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CODE_W-1:0]   pend_q;
    logic                pend_v_q;

    logic                accept;
    logic                hold_expired;

    function automatic logic [N-1:0] onehot(input logic [CODE_W-1:0] idx);
        logic [N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    assign code_ready   = !rst && ((state_q == IDLE) || !pend_v_q);
    assign accept       = code_valid && code_ready;
    assign hold_expired = (HOLD_MAX != 0) && (cnt_q == HOLD_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            gv_q      <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_q <= onehot(code_in);
                        gv_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (ack) begin
                        // Pending slot wins over a same-cycle bypass; no gap cycle either way
                        if (pend_v_q) begin
                            grant_q  <= onehot(pend_q);
                            pend_v_q <= 1'b0;
                            cnt_q    <= '0;
                        end else if (accept) begin
                            grant_q <= onehot(code_in);
                            cnt_q   <= '0;
                        end else begin
                            grant_q <= '0;
                            gv_q    <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        if (accept) begin
                            pend_q   <= code_in;
                            pend_v_q <= 1'b1;
                        end
                        if (hold_expired) begin
                            timeout_q <= 1'b1;
                            grant_q   <= '0;
                            gv_q      <= 1'b0;
                            cnt_q     <= '0;
                            state_q   <= RECOVER;
                        end else if (cnt_q != HOLD_C) begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                RECOVER: begin
                    // A code taken during the dead cycle is granted on the way out
                    if (pend_v_q) begin
                        grant_q  <= onehot(pend_q);
                        gv_q     <= 1'b1;
                        pend_v_q <= 1'b0;
                        cnt_q    <= '0;
                        state_q  <= GRANT;
                    end else if (accept) begin
                        grant_q <= onehot(code_in);
                        gv_q    <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= GRANT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant       = grant_q;
    assign grant_valid = gv_q;
    assign timeout     = timeout_q;
    assign busy        = gv_q || pend_v_q;

endmodule

// File: tb/tb_encoded_grant_decoder.sv
// Randomized and directed bench for encoded_grant_decoder, checked against
// an integer-level grant/pending/hold model.
module tb_encoded_grant_decoder;

    localparam int HOLD = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] code_in = 2'd0;
    logic       code_valid = 1'b0;
    logic       code_ready;
    logic [3:0] grant;
    logic       grant_valid;
    logic       ack = 1'b0;
    logic       timeout;
    logic       busy;

    int vectors = 0;
    int errors  = 0;

    // Model: currently granted index / pending index (-1 = none)
    int m_cur  = -1;
    int m_pend = -1;
    int m_held = 0;
    bit m_rec  = 1'b0;
    bit m_to   = 1'b0;

    logic       o_rdy, e_rdy;
    logic [6:0] o_out, e_out;

    encoded_grant_decoder #(
        .CODE_W  (2),
        .HOLD_MAX(HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .grant      (grant),
        .grant_valid(grant_valid),
        .ack        (ack),
        .timeout    (timeout),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic model_ready();
        return !rst && (m_pend < 0);
    endfunction

    function automatic logic [6:0] model_out();
        logic [3:0] g;
        g = (m_cur >= 0) ? (4'b0001 << m_cur) : 4'b0000;
        return {g, m_cur >= 0, m_to, (m_cur >= 0) || (m_pend >= 0)};
    endfunction

    task automatic model_step(input bit acc);
        m_to = 1'b0;
        if (rst) begin
            m_cur = -1; m_pend = -1; m_held = 0; m_rec = 1'b0;
        end else if (m_rec) begin
            m_rec = 1'b0;
            if (m_pend >= 0) begin
                m_cur = m_pend; m_pend = -1; m_held = 0;
            end else if (acc) begin
                m_cur = int'(code_in); m_held = 0;
            end
        end else if (m_cur < 0) begin
            if (acc) begin m_cur = int'(code_in); m_held = 0; end
        end else if (ack) begin
            if (m_pend >= 0) begin
                m_cur = m_pend; m_pend = -1; m_held = 0;
            end else if (acc) begin
                m_cur = int'(code_in); m_held = 0;
            end else begin
                m_cur = -1;
            end
        end else begin
            if (acc) m_pend = int'(code_in);
            if (HOLD != 0 && m_held == HOLD) begin
                m_to = 1'b1; m_cur = -1; m_rec = 1'b1;
            end else if (m_held < HOLD) begin
                m_held++;
            end
        end
    endtask

    task automatic cycle();
        bit acc;
        @(negedge clk);
        o_rdy = code_ready;
        e_rdy = model_ready();
        acc   = code_valid && e_rdy;
        @(posedge clk);
        model_step(acc);
        #1;
        o_out = {grant, grant_valid, timeout, busy};
        e_out = model_out();
    endtask

    task automatic do_reset();
        rst = 1'b1; code_valid = 1'b0; ack = 1'b0;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; code_valid = 1'b1; code_in = 2'b11; ack = 1'b0;
        repeat (3) begin
            cycle();
            vectors++;
            if (o_rdy !== 1'b0 || grant !== 4'b0000 || grant_valid !== 1'b0) begin
                errors++;
                $display("FAIL reset: ready=%b grant=%b gv=%b, expected ready=0 grant=0000 gv=0",
                         o_rdy, grant, grant_valid);
            end
        end
        rst = 1'b0;
        cycle();
        vectors++;
        if (grant !== 4'b1000 || o_out !== e_out || o_rdy !== e_rdy) begin
            errors++;
            $display("FAIL reset_first_accept: grant=%b out=%b, expected grant=1000 out=%b",
                     grant, o_out, e_out);
        end
        code_valid = 1'b0; ack = 1'b1;
        cycle();
        vectors++;
        if (o_out !== e_out) begin
            errors++;
            $display("FAIL reset_release: out=%b expected %b", o_out, e_out);
        end
    endtask

    task automatic test_sweep();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            code_valid = 1'b1; code_in = c[1:0]; ack = 1'b0;
            cycle();
            vectors++;
            if (grant !== (4'b0001 << c) || o_out !== e_out || o_rdy !== e_rdy) begin
                errors++;
                $display("FAIL sweep_grant%0d: grant=%b out=%b, expected grant=%b out=%b",
                         c, grant, o_out, 4'b0001 << c, e_out);
            end
            code_valid = 1'b0; ack = 1'b1;
            cycle();
            vectors++;
            if (busy !== 1'b0 || o_out !== e_out) begin
                errors++;
                $display("FAIL sweep_release%0d: busy=%b out=%b, expected busy=0 out=%b",
                         c, busy, o_out, e_out);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_pending();
        do_reset();
        code_valid = 1'b1; code_in = 2'd1; ack = 1'b0;
        cycle();
        code_in = 2'd3;
        cycle();
        vectors++;
        if (grant !== 4'b0010 || busy !== 1'b1 || o_out !== e_out) begin
            errors++;
            $display("FAIL pend_load: grant=%b out=%b, expected grant=0010 out=%b",
                     grant, o_out, e_out);
        end
        code_valid = 1'b0;
        cycle();
        vectors++;
        if (o_rdy !== 1'b0 || o_out !== e_out) begin
            errors++;
            $display("FAIL pend_ready: ready=%b out=%b, expected ready=0 out=%b",
                     o_rdy, o_out, e_out);
        end
        ack = 1'b1;
        cycle();
        vectors++;
        if (grant !== 4'b1000 || grant_valid !== 1'b1 || o_out !== e_out) begin
            errors++;
            $display("FAIL pend_switch: grant=%b gv=%b, expected grant=1000 gv=1",
                     grant, grant_valid);
        end
        cycle();
        vectors++;
        if (o_out !== e_out || o_rdy !== e_rdy) begin
            errors++;
            $display("FAIL pend_release: out=%b expected %b", o_out, e_out);
        end
        ack = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        code_valid = 1'b1; code_in = 2'd2; ack = 1'b0;
        cycle();
        code_valid = 1'b0;
        for (int i = 0; i < HOLD; i++) begin
            cycle();
            vectors++;
            if (grant !== 4'b0100 || timeout !== 1'b0 || o_out !== e_out) begin
                errors++;
                $display("FAIL timeout_hold%0d: grant=%b to=%b, expected grant=0100 to=0",
                         i, grant, timeout);
            end
        end
        cycle();
        vectors++;
        if (timeout !== 1'b1 || grant !== 4'b0000 || grant_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fire: to=%b grant=%b gv=%b, expected to=1 grant=0000 gv=0",
                     timeout, grant, grant_valid);
        end
        repeat (2) begin
            cycle();
            vectors++;
            if (timeout !== 1'b0 || o_out !== e_out || o_rdy !== e_rdy) begin
                errors++;
                $display("FAIL timeout_recover: out=%b expected %b", o_out, e_out);
            end
        end
        code_valid = 1'b1; code_in = 2'd2;
        cycle();
        code_valid = 1'b0;
        repeat (HOLD) cycle();
        ack = 1'b1;
        cycle();
        vectors++;
        if (timeout !== 1'b0 || grant_valid !== 1'b0 || o_out !== e_out) begin
            errors++;
            $display("FAIL timeout_ack_wins: to=%b gv=%b, expected to=0 gv=0",
                     timeout, grant_valid);
        end
        ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        code_valid = 1'b1; code_in = 2'd1; ack = 1'b0;
        cycle();
        code_in = 2'd2;
        cycle();
        code_valid = 1'b0; rst = 1'b1;
        cycle();
        vectors++;
        if (grant !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: grant=%b busy=%b to=%b, expected 0000/0/0",
                     grant, busy, timeout);
        end
        rst = 1'b0; ack = 1'b1;
        repeat (3) begin
            cycle();
            vectors++;
            if (grant_valid !== 1'b0 || o_out !== e_out) begin
                errors++;
                $display("FAIL reset_mid_drop: gv=%b out=%b, expected gv=0 out=%b",
                         grant_valid, o_out, e_out);
            end
        end
        ack = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [1:0] c;
        do_reset();
        code_valid = 1'b1; code_in = 2'd2; ack = 1'b0;
        cycle();
        code_in = 2'd0; ack = 1'b1;
        cycle();
        vectors++;
        if (grant !== 4'b0001 || grant_valid !== 1'b1 || o_out !== e_out) begin
            errors++;
            $display("FAIL b2b_bypass: grant=%b gv=%b, expected grant=0001 gv=1",
                     grant, grant_valid);
        end
        for (int i = 0; i < 8; i++) begin
            c = 2'($urandom);
            code_in = c;
            cycle();
            vectors++;
            if (grant !== (4'b0001 << c) || grant_valid !== 1'b1 || o_out !== e_out) begin
                errors++;
                $display("FAIL b2b_stream%0d: grant=%b, expected %b", i, grant, 4'b0001 << c);
            end
        end
        code_valid = 1'b0;
        cycle();
        ack = 1'b0;
    endtask

    task automatic test_random();
        int ack_den;
        do_reset();
        for (int i = 0; i < 800; i++) begin
            ack_den    = (i < 400) ? 24 : 3;
            rst        = ($urandom_range(0, 59) == 0);
            code_valid = $urandom_range(0, 1) == 1;
            code_in    = 2'($urandom);
            ack        = ($urandom_range(0, ack_den - 1) == 0);
            cycle();
            vectors++;
            if (o_out !== e_out || o_rdy !== e_rdy) begin
                errors++;
                $display("FAIL random%0d: ready=%b out=%b, expected ready=%b out=%b",
                         i, o_rdy, o_out, e_rdy, e_out);
            end
        end
        rst = 1'b0; code_valid = 1'b0; ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_sweep();
        test_pending();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
